// File: rtl/writeback_queue.sv
// writeback_queue: write-back FIFO feeding the register file, with read-port bypass from queued entries.
module writeback_queue #(
  parameter int N = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [3:0]               alu_reg,
  input  logic [N-1:0]             alu_data,
  input  logic                     mem_valid,
  input  logic [3:0]               mem_reg,
  input  logic [N-1:0]             mem_data,
  output logic                     in_ready,
  output logic                     reg_write,
  output logic [3:0]               write_register,
  output logic [N-1:0]             write_data,
  input  logic [3:0]               read_register1,
  input  logic [3:0]               read_register2,
  input  logic [N-1:0]             rf_read_data1,
  input  logic [N-1:0]             rf_read_data2,
  output logic [N-1:0]             fwd_data1,
  output logic [N-1:0]             fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [3:0]    reg_q [DEPTH];
  logic [N-1:0]  dat_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, mem_slot;
  logic [CW-1:0] count_q, count_d, free;
  logic          ovf_q, ovf_d, pop, alu_acc, mem_acc;
  // Free slots include the one vacated by this cycle's pop; ALU claims first.
  always_comb begin
    pop      = count_q != '0;
    free     = CW'(DEPTH) - count_q + CW'(pop);
    alu_acc  = alu_valid && free != '0;
    mem_acc  = mem_valid && free > CW'(alu_acc);
    mem_slot = alu_acc ? tail_q + AW'(1) : tail_q;
    tail_d   = tail_q + AW'(alu_acc) + AW'(mem_acc);
    head_d   = head_q + AW'(pop);
    count_d  = count_q + CW'(alu_acc) + CW'(mem_acc) - CW'(pop);
    ovf_d    = ovf_q || (alu_valid && !alu_acc) || (mem_valid && !mem_acc);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (alu_acc) begin
      reg_q[tail_q] <= alu_reg;
      dat_q[tail_q] <= alu_data;
    end
    if (mem_acc) begin
      reg_q[mem_slot] <= mem_reg;
      dat_q[mem_slot] <= mem_data;
    end
  end
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_data1 = rf_read_data1;
    fwd_data2 = rf_read_data2;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && reg_q[head_q + AW'(i)] == read_register1) fwd_data1 = dat_q[head_q + AW'(i)];
      if (CW'(i) < count_q && reg_q[head_q + AW'(i)] == read_register2) fwd_data2 = dat_q[head_q + AW'(i)];
    end
  end
  assign in_ready       = (CW'(DEPTH) - count_q) >= CW'(2);
  assign reg_write      = pop;
  assign write_register = reg_q[head_q];
  assign write_data     = dat_q[head_q];
  assign count          = count_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and randomized checks of writeback_queue against a queue-based reference model.
module tb_writeback_queue;
  localparam int N = 32;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic alu_valid = 0, mem_valid = 0;
  logic [3:0] alu_reg = 0, mem_reg = 0, read_register1 = 0, read_register2 = 0;
  logic [N-1:0] alu_data = 0, mem_data = 0, rf_read_data1 = 0, rf_read_data2 = 0;
  logic in_ready, reg_write, overflow;
  logic [3:0] write_register;
  logic [N-1:0] write_data, fwd_data1, fwd_data2;
  logic [2:0] count;
  int vectors = 0, errors = 0;
  logic [N+3:0] q[$];
  bit m_ovf = 0;

  writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .in_ready(in_ready),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .read_register1(read_register1), .read_register2(read_register2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_fwd(input logic [3:0] rr, input logic [N-1:0] rf);
    logic [N-1:0] r = rf;
    foreach (q[i]) if (q[i][N+3:N] == rr) r = q[i][N-1:0];
    return r;
  endfunction

  // One clock with the given requests; the model applies pop then enqueues in age order.
  task automatic cyc(input bit av, input logic [3:0] ar, input logic [N-1:0] ad,
                     input bit mv, input logic [3:0] mr, input logic [N-1:0] md);
    int free;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    @(posedge clk);
    free = DEPTH - q.size();
    if (q.size() > 0) begin q.delete(0); free++; end
    if (av) begin if (free > 0) begin q.push_back({ar, ad}); free--; end else m_ovf = 1; end
    if (mv) begin if (free > 0) begin q.push_back({mr, md}); free--; end else m_ovf = 1; end
    #1;
    alu_valid = 0; mem_valid = 0;
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    rst = 0;
    #12;
    vectors++;
    if ({count, reg_write, overflow, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset: got cnt/we/ovf/rdy=%b required %b", {count, reg_write, overflow, in_ready}, {3'd0, 3'b001});
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    cyc(1, 3, 32'hAAAA0001, 0, 0, 0);
    vectors++;
    if ({reg_write, write_register, write_data, count} !== {1'b1, 4'd3, 32'hAAAA0001, 3'd1}) begin
      errors++; $display("FAIL single_head: got we=%b r=%0d d=%h cnt=%0d required 1 3 aaaa0001 1", reg_write, write_register, write_data, count);
    end
    idle();
    vectors++;
    if ({reg_write, count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL single_drain: got we=%b cnt=%0d required 0 0", reg_write, count);
    end
  endtask

  task automatic test_same_reg();
    read_register1 = 5; rf_read_data1 = 32'h99;
    cyc(1, 5, 32'h11, 1, 5, 32'h22);
    vectors++;
    if ({reg_write, write_register, write_data, count, fwd_data1} !== {1'b1, 4'd5, 32'h11, 3'd2, 32'h22}) begin
      errors++; $display("FAIL same_reg_first: got we=%b r=%0d d=%h cnt=%0d fwd=%h required 1 5 11 2 22", reg_write, write_register, write_data, count, fwd_data1);
    end
    idle();
    vectors++;
    if ({reg_write, write_register, write_data, count, fwd_data1} !== {1'b1, 4'd5, 32'h22, 3'd1, 32'h22}) begin
      errors++; $display("FAIL same_reg_second: got we=%b r=%0d d=%h cnt=%0d fwd=%h required 1 5 22 1 22", reg_write, write_register, write_data, count, fwd_data1);
    end
    idle();
    vectors++;
    if ({reg_write, count, fwd_data1} !== {1'b0, 3'd0, 32'h99}) begin
      errors++; $display("FAIL same_reg_empty: got we=%b cnt=%0d fwd=%h required 0 0 99", reg_write, count, fwd_data1);
    end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] exp_cnt [4] = '{3'd2, 3'd3, 3'd4, 3'd4};
    logic [3:0] exp_ro = 4'b1000;
    logic [3:0] exp_ovf = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'(2 * i), 32'h100 + i, 1, 4'(2 * i + 1), 32'h200 + i);
      vectors++;
      if ({count, in_ready, overflow} !== {exp_cnt[i], exp_ro[3 - i], exp_ovf[3 - i]}) begin
        errors++; $display("FAIL fill_%0d: got cnt=%0d rdy=%b ovf=%b required %0d %b %b", i, count, in_ready, overflow, exp_cnt[i], exp_ro[3 - i], exp_ovf[3 - i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (q.size() > 0 && {reg_write, write_register, write_data} !== {1'b1, q[0]}) begin
        errors++; $display("FAIL drain_%0d: got we=%b r=%0d d=%h required 1 %0d %h", i, reg_write, write_register, write_data, q[0][N+3:N], q[0][N-1:0]);
      end
      if (q.size() == 0 && reg_write !== 1'b0) begin
        errors++; $display("FAIL drain_%0d: got we=%b required 0", i, reg_write);
      end
      idle();
    end
    vectors++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_empty_fwd();
    read_register2 = 7; rf_read_data2 = 32'hDEAD;
    #1;
    vectors++;
    if ({count, fwd_data2} !== {3'd0, 32'hDEAD}) begin
      errors++; $display("FAIL empty_fwd: got cnt=%0d fwd2=%h required 0 dead", count, fwd_data2);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 32'hA1, 1, 2, 32'hA2);
    cyc(1, 3, 32'hA3, 1, 4, 32'hA4);
    vectors++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL pre_reset_cnt: got %0d required 3", count);
    end
    #2 rst = 0;
    #1;
    q.delete(); m_ovf = 0;
    vectors++;
    if ({count, reg_write, overflow} !== {3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset: got cnt=%0d we=%b ovf=%b required 0 0 0", count, reg_write, overflow);
    end
    @(posedge clk); #1;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    vectors++;
    if (reg_write !== 1'b0) begin
      errors++; $display("FAIL post_reset_write: got we=%b required 0", reg_write);
    end
    cyc(0, 0, 0, 1, 9, 32'hBEEF);
    vectors++;
    if ({reg_write, write_register, write_data, count} !== {1'b1, 4'd9, 32'hBEEF, 3'd1}) begin
      errors++; $display("FAIL post_reset_accept: got we=%b r=%0d d=%h cnt=%0d required 1 9 beef 1", reg_write, write_register, write_data, count);
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [3:0] regs [6] = '{4'd0, 4'd15, 4'd6, 4'd0, 4'd11, 4'd2};
    for (int i = 0; i < 6; i++) begin
      cyc(i % 2 == 0, regs[i], 32'hC000 + i, i % 2 == 1, regs[i], 32'hC000 + i);
      vectors++;
      if ({reg_write, write_register, write_data, count} !== {1'b1, regs[i], 32'hC000 + i, 3'd1}) begin
        errors++; $display("FAIL wrap_%0d: got we=%b r=%0d d=%h cnt=%0d required 1 %0d %h 1", i, reg_write, write_register, write_data, count, regs[i], 32'hC000 + i);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      read_register1 = 4'($urandom); read_register2 = 4'($urandom);
      rf_read_data1 = $urandom; rf_read_data2 = $urandom;
      cyc($urandom_range(0, 2) == 0, 4'($urandom), $urandom, $urandom_range(0, 3) == 0, 4'($urandom), $urandom);
      vectors++;
      if ({reg_write, count, in_ready, overflow, fwd_data1, fwd_data2} !==
          {q.size() > 0, 3'(q.size()), (DEPTH - q.size()) >= 2, m_ovf,
           model_fwd(read_register1, rf_read_data1), model_fwd(read_register2, rf_read_data2)}) begin
        errors++; $display("FAIL rand_%0d: got we=%b cnt=%0d rdy=%b ovf=%b f1=%h f2=%h required cnt=%0d ovf=%b f1=%h f2=%h",
          i, reg_write, count, in_ready, overflow, fwd_data1, fwd_data2, q.size(), m_ovf,
          model_fwd(read_register1, rf_read_data1), model_fwd(read_register2, rf_read_data2));
      end
      if (q.size() > 0) begin
        vectors++;
        if ({write_register, write_data} !== q[0]) begin
          errors++; $display("FAIL rand_head_%0d: got r=%0d d=%h required %0d %h", i, write_register, write_data, q[0][N+3:N], q[0][N-1:0]);
        end
      end
      if (i == 200) begin
        rst = 0; #1; q.delete(); m_ovf = 0;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_reg();
    test_fill_overflow();
    test_empty_fwd();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
